// File: rtl/fc_layer_seq.sv
// Time-multiplexed fully connected layer: one signed MAC, streamed I/O, run-time weight/bias memories.
// Optional ReLU on the saturated output when FC_RELU_EN is defined.
`timescale 1ns/1ps
module fc_layer_seq #(
  parameter int IN_LEN  = 16,
  parameter int OUT_LEN = 8,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int SHIFT   = 0
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic signed [DATA_W-1:0]                         in_data,
  input  logic                                             w_we,
  input  logic [$clog2(IN_LEN*OUT_LEN)-1:0]                w_addr,
  input  logic signed [DATA_W-1:0]                         w_data,
  input  logic                                             b_we,
  input  logic [((OUT_LEN > 1) ? $clog2(OUT_LEN) : 1)-1:0] b_addr,
  input  logic signed [DATA_W-1:0]                         b_data,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic signed [DATA_W-1:0]                         out_data,
  output logic                                             out_last,
  output logic                                             busy
);

  localparam int WA_W   = $clog2(IN_LEN*OUT_LEN);
  localparam int BA_W   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int XI_W   = $clog2(IN_LEN);
  localparam int IDX_W  = $clog2(IN_LEN+1);
  localparam int PROD_W = 2*DATA_W;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(IN_LEN-1);
  localparam logic [IDX_W-1:0] IDX_DRAIN = IDX_W'(IN_LEN);
  localparam logic [BA_W-1:0]  K_LAST    = BA_W'(OUT_LEN-1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_EMIT} state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] w_mem [2**WA_W];
  logic signed [DATA_W-1:0] b_mem [2**BA_W];
  logic signed [DATA_W-1:0] x_buf [2**XI_W];

  logic             armed_q;
  logic [IDX_W-1:0] in_cnt;
  logic [IDX_W-1:0] idx_cnt;
  logic [BA_W-1:0]  k_cnt;
  logic             accept;
  logic             issue;
  logic             drain;
  logic             emit_hs;

  logic [WA_W-1:0]          w_rd_addr;
  logic [XI_W-1:0]          x_rd_idx;
  logic [XI_W-1:0]          x_wr_idx;
  logic signed [PROD_W-1:0] w_op;
  logic signed [PROD_W-1:0] x_op;

  logic signed [PROD_W-1:0] prod_p0;
  logic                     vld_p0;
  logic                     first_p0;

  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  acc_shr;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [DATA_W-1:0] bias;
  logic signed [DATA_W-1:0] result_p1;

  function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

`ifdef FC_RELU_EN
  function automatic logic signed [DATA_W-1:0] act_fn(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? '0 : v;
  endfunction
`else
  function automatic logic signed [DATA_W-1:0] act_fn(input logic signed [DATA_W-1:0] v);
    return v;
  endfunction
`endif

  // Control: in_ready is held off until the first clock after reset release
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = (state_q != S_IDLE);
    issue     = 1'b0;
    drain     = 1'b0;
    emit_hs   = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = armed_q;
        accept   = in_valid && armed_q;
        if (accept) state_d = S_LOAD;
      end
      S_LOAD: begin
        in_ready = armed_q;
        accept   = in_valid && armed_q;
        if (accept && (in_cnt == IDX_LAST)) state_d = S_MAC;
      end
      S_MAC: begin
        if (idx_cnt == IDX_DRAIN) begin
          drain   = 1'b1;
          state_d = S_EMIT;
        end else begin
          issue = 1'b1;
        end
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_last  = (k_cnt == K_LAST);
        if (out_ready) begin
          emit_hs = 1'b1;
          state_d = (k_cnt == K_LAST) ? S_IDLE : S_MAC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      armed_q  <= 1'b0;
      in_cnt   <= '0;
      idx_cnt  <= '0;
      k_cnt    <= '0;
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      out_data <= '0;
    end else begin
      state_q  <= state_d;
      armed_q  <= 1'b1;
      vld_p0   <= issue;
      first_p0 <= issue && (idx_cnt == '0);
      if (accept) in_cnt <= (state_q == S_IDLE) ? IDX_W'(1) : in_cnt + IDX_W'(1);
      if (issue) begin
        idx_cnt <= idx_cnt + IDX_W'(1);
      end else if (drain) begin
        idx_cnt <= '0;
      end
      if (drain) out_data <= result_p1;
      if (emit_hs) k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + BA_W'(1);
    end
  end

  assign w_rd_addr = WA_W'(int'(k_cnt) * IN_LEN + int'(idx_cnt));
  assign x_rd_idx  = idx_cnt[XI_W-1:0];
  assign x_wr_idx  = (state_q == S_IDLE) ? '0 : in_cnt[XI_W-1:0];
  assign w_op      = {{(PROD_W-DATA_W){w_mem[w_rd_addr][DATA_W-1]}}, w_mem[w_rd_addr]};
  assign x_op      = {{(PROD_W-DATA_W){x_buf[x_rd_idx][DATA_W-1]}}, x_buf[x_rd_idx]};
  assign bias      = b_mem[k_cnt];

  // Stage p1: accumulate; the first product of a neuron restarts from the bias
  always_comb begin
    prod_ext  = {{(ACC_W-PROD_W){prod_p0[PROD_W-1]}}, prod_p0};
    bias_ext  = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
    acc_next  = first_p0 ? (bias_ext + prod_ext) : (acc_p1 + prod_ext);
    acc_shr   = acc_next >>> SHIFT;
    result_p1 = act_fn(sat_fn(acc_shr));
  end

  // Stage p0: operand fetch and multiply; memories only change while idle
  always_ff @(posedge clk) begin
    if (accept) x_buf[x_wr_idx] <= in_data;
    if (w_we && (state_q == S_IDLE)) w_mem[w_addr] <= w_data;
    if (b_we && (state_q == S_IDLE)) b_mem[b_addr] <= b_data;
    if (issue) prod_p0 <= w_op * x_op;
    if (vld_p0) acc_p1 <= acc_next;
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench for fc_layer_seq (IN_LEN=4, OUT_LEN=2, DATA_W=8, ACC_W=20, SHIFT=0).
`timescale 1ns/1ps
module tb_fc_layer_seq;
  localparam int IN_LEN  = 4;
  localparam int OUT_LEN = 2;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 20;
  localparam int SHIFT   = 0;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic              w_we;
  logic [2:0]        w_addr;
  logic signed [7:0] w_data;
  logic              b_we;
  logic [0:0]        b_addr;
  logic signed [7:0] b_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;
  logic              out_last;
  logic              busy;

  typedef struct {
    logic signed [7:0] data;
    logic              last;
  } exp_t;

  exp_t sb[$];
  int   w_m[8];
  int   b_m[2];
  int   vec[4];
  int   n_checks = 0;
  int   n_pass   = 0;

  fc_layer_seq #(
    .IN_LEN (IN_LEN),
    .OUT_LEN(OUT_LEN),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [7:0] model(input int n);
    int acc;
    acc = b_m[n];
    for (int i = 0; i < IN_LEN; i++) acc += w_m[n*IN_LEN+i] * vec[i];
    acc = acc >>> SHIFT;
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
`ifdef FC_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return 8'(acc);
  endfunction

  task automatic drive_wb(input bit we, input int wa, input int wd,
                          input bit be, input int ba, input int bd);
    w_we = we; w_addr = 3'(wa); w_data = 8'(wd);
    b_we = be; b_addr = 1'(ba); b_data = 8'(bd);
    @(posedge clk); #1;
    w_we = 1'b0; b_we = 1'b0;
  endtask

  task automatic wr_wb(input bit we, input int wa, input int wd,
                       input bit be, input int ba, input int bd);
    if (we) w_m[wa] = wd;
    if (be) b_m[ba] = bd;
    drive_wb(we, wa, wd, be, ba, bd);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 4; i++) wr_wb(1'b1, i, i + 1, i < 2, i, (i == 0) ? 10 : 0);
    for (int i = 0; i < 4; i++) wr_wb(1'b1, 4 + i, -10, 1'b0, 0, 0);
  endtask

  task automatic load_uniform(input int wv, input int bv);
    for (int a = 0; a < 8; a++) wr_wb(1'b1, a, wv, a < 2, a, bv);
  endtask

  task automatic send_vector(input int gap);
    exp_t e;
    int   t;
    for (int i = 0; i < IN_LEN; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(vec[i]);
      t = 0;
      while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i < IN_LEN - 1) repeat (gap) begin @(posedge clk); #1; end
    end
    for (int n = 0; n < OUT_LEN; n++) begin
      e.data = model(n);
      e.last = (n == OUT_LEN - 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_out(input int budget, output int waited);
    waited = 0;
    while (!out_valid && waited < budget) begin @(posedge clk); #1; waited++; end
  endtask

  task automatic take(output logic signed [7:0] d, output logic l);
    d = out_data;
    l = out_last;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_last, busy} !== 4'b0000 || out_data !== 8'sd0)
      $display("FAIL reset_outputs in_ready=%b out_valid=%b out_last=%b busy=%b out_data=%0d want all 0",
               in_ready, out_valid, out_last, busy, out_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_release in_ready=%b want 0 before first edge", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready in_ready=%b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    int t; logic signed [7:0] d; logic l; exp_t e;
    load_basic();
    vec = '{1, 1, 1, 1};
    send_vector(0);
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL basic_busy in_ready=%b busy=%b want 0/1", in_ready, busy);
    else n_pass++;
    for (int r = 0; r < OUT_LEN; r++) begin
      wait_out(40, t);
      n_checks++;
      if (t !== 5) $display("FAIL basic_latency%0d got %0d cycles want 5", r, t);
      else n_pass++;
      e = sb.pop_front();
      take(d, l);
      n_checks++;
      if (d !== e.data || l !== e.last)
        $display("FAIL basic_r%0d data=%0d last=%b want data=%0d last=%b", r, d, l, e.data, e.last);
      else n_pass++;
    end
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL basic_idle in_ready=%b busy=%b want 1/0", in_ready, busy);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int t; logic signed [7:0] d; logic l; exp_t e;
    for (int p = 0; p < 2; p++) begin
      load_uniform((p == 0) ? 127 : -128, 127);
      vec = '{127, 127, 127, 127};
      send_vector(0);
      for (int r = 0; r < OUT_LEN; r++) begin
        wait_out(40, t);
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL sat%0d_timeout out_valid=%b want 1", p, out_valid);
        else n_pass++;
        e = sb.pop_front();
        take(d, l);
        n_checks++;
        if (d !== e.data || l !== e.last)
          $display("FAIL sat%0d_r%0d data=%0d last=%b want data=%0d last=%b", p, r, d, l, e.data, e.last);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int t; logic signed [7:0] d; logic l; exp_t e;
    load_basic();
    vec = '{1, 1, 1, 1};
    send_vector(0);
    for (int r = 0; r < OUT_LEN; r++) begin
      wait_out(40, t);
      e = sb.pop_front();
      if (r == 0) begin
        repeat (5) begin
          @(posedge clk); #1;
          n_checks++;
          if (out_valid !== 1'b1 || out_data !== e.data || out_last !== e.last || in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL bp_hold out_valid=%b data=%0d last=%b in_ready=%b busy=%b want 1/%0d/%b/0/1",
                     out_valid, out_data, out_last, in_ready, busy, e.data, e.last);
          else n_pass++;
        end
      end
      take(d, l);
      n_checks++;
      if (d !== e.data || l !== e.last)
        $display("FAIL bp_r%0d data=%0d last=%b want data=%0d last=%b", r, d, l, e.data, e.last);
      else n_pass++;
    end
  endtask

  task automatic test_gaps();
    int t; logic signed [7:0] d; logic l; exp_t e;
    load_basic();
    for (int p = 0; p < 2; p++) begin
      if (p == 0) vec = '{1, 1, 1, 1};
      else        vec = '{2, -1, 3, -5};
      send_vector((p == 0) ? 3 : 1);
      for (int r = 0; r < OUT_LEN; r++) begin
        wait_out(40, t);
        n_checks++;
        if (t !== 5) $display("FAIL gap%0d_latency%0d got %0d cycles want 5", p, r, t);
        else n_pass++;
        e = sb.pop_front();
        take(d, l);
        n_checks++;
        if (d !== e.data || l !== e.last)
          $display("FAIL gap%0d_r%0d data=%0d last=%b want data=%0d last=%b", p, r, d, l, e.data, e.last);
        else n_pass++;
      end
    end
  endtask

  task automatic test_write_busy();
    int t; logic signed [7:0] d; logic l; exp_t e;
    load_basic();
    vec = '{1, 1, 1, 1};
    for (int p = 0; p < 2; p++) begin
      if (p == 1) wr_wb(1'b1, 0, 50, 1'b0, 0, 0);
      send_vector(0);
      if (p == 0) drive_wb(1'b1, 0, 50, 1'b1, 0, 99);
      for (int r = 0; r < OUT_LEN; r++) begin
        wait_out(40, t);
        if (p == 0 && r == 0) drive_wb(1'b1, 4, 77, 1'b1, 1, 55);
        e = sb.pop_front();
        take(d, l);
        n_checks++;
        if (d !== e.data || l !== e.last)
          $display("FAIL wbusy%0d_r%0d data=%0d last=%b want data=%0d last=%b", p, r, d, l, e.data, e.last);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int t; logic signed [7:0] d; logic l; exp_t e;
    vec = '{3, 3, 3, 3};
    send_vector(0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_last, busy} !== 4'b0000 || out_data !== 8'sd0)
      $display("FAIL midrst_outputs in_ready=%b out_valid=%b out_last=%b busy=%b out_data=%0d want all 0",
               in_ready, out_valid, out_last, busy, out_data);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL midrst_idle in_ready=%b busy=%b want 1/0", in_ready, busy);
    else n_pass++;
    wait_out(12, t);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midrst_partial out_valid=%b want 0", out_valid);
    else n_pass++;
    vec = '{1, 1, 1, 1};
    send_vector(0);
    for (int r = 0; r < OUT_LEN; r++) begin
      wait_out(40, t);
      e = sb.pop_front();
      take(d, l);
      n_checks++;
      if (d !== e.data || l !== e.last)
        $display("FAIL midrst_r%0d data=%0d last=%b want data=%0d last=%b", r, d, l, e.data, e.last);
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    w_we      = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    b_we      = 1'b0;
    b_addr    = '0;
    b_data    = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_gaps();
    test_write_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
